// File: rtl/pair_triple_bist_pkg.sv
// Shared types, constants and the majority reference for the pair/triple BIST.
package pair_triple_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int PATTERNS = 8;
  localparam int ERR_W    = 8;

  // Golden answer: true when at least two of the three inputs are set.
  function automatic logic majority3(input logic [2:0] p);
    return (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
  endfunction

endpackage

// File: rtl/bist_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module bist_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic [W-1:0] count_next
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/pair_triple_bist.sv
// Sweeps all 3-bit patterns into a majority detector PASSES times, holding each
// for SETTLE cycles, and tallies mismatches against the majority reference.
module pair_triple_bist
  import pair_triple_bist_pkg::*;
#(
  parameter int PASSES = 1,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [2:0]       first_err_pattern,
  output logic             dut_in0,
  output logic             dut_in1,
  output logic             dut_in2,
  input  logic             dut_out,
  output logic [1:0]       dbg_state
);

  localparam int              SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_INIT = SW'(SETTLE - 1);
  localparam logic [7:0]      LAST_PASS   = 8'(PASSES - 1);
  localparam logic [2:0]      LAST_PAT    = 3'(PATTERNS - 1);

  // start is a level sampled on the rising edge; it is only acted on in IDLE or
  // DONE. busy covers DRIVE+SAMPLE, done holds until the next accepted start.
  state_t        state_q, state_d;
  logic [2:0]    pattern_q, pattern_d;
  logic [7:0]    pass_cnt_q, pass_cnt_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic          fev_q, fev_d;
  logic [2:0]    fep_q, fep_d;
  logic          cnt_clr, cnt_inc;
  logic [ERR_W-1:0] err_cnt, err_cnt_next;
  logic          mismatch;

  assign mismatch = (dut_out != majority3(pattern_q));

  always_comb begin
    state_d    = state_q;
    pattern_d  = pattern_q;
    pass_cnt_d = pass_cnt_q;
    settle_d   = settle_q;
    fev_d      = fev_q;
    fep_d      = fep_q;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = DRIVE;
          pattern_d  = '0;
          pass_cnt_d = '0;
          settle_d   = SETTLE_INIT;
          fev_d      = 1'b0;
          fep_d      = '0;
          cnt_clr    = 1'b1;
        end
      end
      DRIVE: begin
        if (settle_q == '0) begin
          state_d = SAMPLE;
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      SAMPLE: begin
        if (mismatch) begin
          cnt_inc = 1'b1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fep_d = pattern_q;
          end
        end
        settle_d = SETTLE_INIT;
        if (pattern_q != LAST_PAT) begin
          pattern_d = pattern_q + 3'd1;
          state_d   = DRIVE;
        end else begin
          pattern_d = '0;
          if (pass_cnt_q != LAST_PASS) begin
            pass_cnt_d = pass_cnt_q + 8'd1;
            state_d    = DRIVE;
          end else begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRIVE) || (state_d == SAMPLE);
    done_d = (state_d == DONE);
    // Uses the counter's next value so the final sample is reflected in pass.
    pass_d = (state_d == DONE) && (err_cnt_next == '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      pattern_q  <= '0;
      pass_cnt_q <= '0;
      settle_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fev_q      <= 1'b0;
      fep_q      <= '0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      pass_cnt_q <= pass_cnt_d;
      settle_q   <= settle_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fev_q      <= fev_d;
      fep_q      <= fep_d;
    end
  end

  bist_sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .count      (err_cnt),
    .count_next (err_cnt_next)
  );

  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_count         = err_cnt;
  assign first_err_valid   = fev_q;
  assign first_err_pattern = fep_q;
  assign dut_in0           = pattern_q[2];
  assign dut_in1           = pattern_q[1];
  assign dut_in2           = pattern_q[0];
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_pair_triple_bist.sv
// Randomized scoreboard bench: three BIST instances drive modelled detectors
// with per-pattern fault masks; results are predicted from the majority rule.
module tb_pair_triple_bist;

  localparam int PA = 1;   localparam int SA = 1;
  localparam int PB = 100; localparam int SB = 1;
  localparam int PC = 3;   localparam int SC = 3;
  localparam int NA = 8 * PA * (SA + 1);
  localparam int NB = 8 * PB * (SB + 1);
  localparam int NC = 8 * PC * (SC + 1);
  localparam int W  = 45;

  logic clk, rst_n;
  int   cyc;
  int   n_chk, n_pass;

  logic start_a, start_b, start_c;
  logic [7:0] mask_a, mask_b, mask_c;
  logic busy_a, done_a, pass_a, fev_a, in0_a, in1_a, in2_a, out_a;
  logic busy_b, done_b, pass_b, fev_b, in0_b, in1_b, in2_b, out_b;
  logic busy_c, done_c, pass_c, fev_c, in0_c, in1_c, in2_c, out_c;
  logic [7:0] err_a, err_b, err_c;
  logic [2:0] fep_a, fep_b, fep_c;
  logic [1:0] st_a, st_b, st_c;

  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [W-1:0] exp_c_q[$];

  // ---------------- reference model ----------------
  function automatic logic det(input logic [7:0] mask, input logic [2:0] p);
    return ($countones(p) >= 2) ^ mask[p];
  endfunction

  function automatic logic [7:0] stuck_mask(input logic val);
    logic [7:0] m;
    logic [2:0] p3;
    for (int p = 0; p < 8; p++) begin
      p3   = 3'(p);
      m[p] = (($countones(p3) >= 2) != val);
    end
    return m;
  endfunction

  // {pass, err_count, first_err_valid, first_err_pattern}
  function automatic logic [12:0] ref_result(input logic [7:0] mask, input int passes);
    int n;
    int first;
    n = 0;
    first = -1;
    for (int p = 0; p < 8; p++) begin
      if (mask[p]) begin
        n++;
        if (first < 0) first = p;
      end
    end
    n = n * passes;
    if (n > 255) n = 255;
    return {(n == 0), 8'(n), (first >= 0), (first >= 0) ? 3'(first) : 3'd0};
  endfunction

  assign out_a = det(mask_a, {in0_a, in1_a, in2_a});
  assign out_b = det(mask_b, {in0_b, in1_b, in2_b});
  assign out_c = det(mask_c, {in0_c, in1_c, in2_c});

  // ---------------- DUTs ----------------
  pair_triple_bist #(.PASSES(PA), .SETTLE(SA)) u_dut_a (
    .clk(clk), .reset(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_valid(fev_a),
    .first_err_pattern(fep_a), .dut_in0(in0_a), .dut_in1(in1_a),
    .dut_in2(in2_a), .dut_out(out_a), .dbg_state(st_a));

  pair_triple_bist #(.PASSES(PB), .SETTLE(SB)) u_dut_b (
    .clk(clk), .reset(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_valid(fev_b),
    .first_err_pattern(fep_b), .dut_in0(in0_b), .dut_in1(in1_b),
    .dut_in2(in2_b), .dut_out(out_b), .dbg_state(st_b));

  pair_triple_bist #(.PASSES(PC), .SETTLE(SC)) u_dut_c (
    .clk(clk), .reset(rst_n), .start(start_c), .busy(busy_c), .done(done_c),
    .pass(pass_c), .err_count(err_c), .first_err_valid(fev_c),
    .first_err_pattern(fep_c), .dut_in0(in0_c), .dut_in1(in1_c),
    .dut_in2(in2_c), .dut_out(out_c), .dbg_state(st_c));

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic cmp_result(input string tag, input logic [W-1:0] e, input logic ps,
                            input logic [7:0] er, input logic fv, input logic [2:0] fp);
    chk({tag, "_done_cycle"}, 32'(cyc), e[44:13]);
    chk({tag, "_pass"}, 32'(ps), 32'(e[12]));
    chk({tag, "_err_count"}, 32'(er), 32'(e[11:4]));
    chk({tag, "_first_err_valid"}, 32'(fv), 32'(e[3]));
    chk({tag, "_first_err_pattern"}, 32'(fp), 32'(e[2:0]));
  endtask

  // ---------------- monitors ----------------
  logic done_a_prev, done_b_prev, done_c_prev;
  initial begin
    done_a_prev = 1'b0;
    done_b_prev = 1'b0;
    done_c_prev = 1'b0;
  end

  // A: per-cycle sweep order/hold check plus end-of-run result.
  always @(negedge clk) begin
    int k, m;
    logic [W-1:0] e;
    if (rst_n) begin
      if (exp_a_q.size() != 0) begin
        k = int'(exp_a_q[0][44:13]) - NA;
        m = cyc - k;
        if (m >= 0 && m < NA) begin
          chk("a_busy_in_run", 32'(busy_a), 32'd1);
          chk("a_done_in_run", 32'(done_a), 32'd0);
          chk("a_pattern", 32'({in0_a, in1_a, in2_a}), 32'((m / (SA + 1)) % 8));
        end
      end
      if (done_a && !done_a_prev) begin
        if (exp_a_q.size() == 0) chk("a_unexpected_done", 32'd1, 32'd0);
        else begin
          e = exp_a_q.pop_front();
          cmp_result("a", e, pass_a, err_a, fev_a, fep_a);
          chk("a_busy_at_done", 32'(busy_a), 32'd0);
        end
      end
    end
    done_a_prev = done_a;
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && done_b && !done_b_prev) begin
      if (exp_b_q.size() == 0) chk("b_unexpected_done", 32'd1, 32'd0);
      else begin
        e = exp_b_q.pop_front();
        cmp_result("b", e, pass_b, err_b, fev_b, fep_b);
      end
    end
    done_b_prev = done_b;
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && done_c && !done_c_prev) begin
      if (exp_c_q.size() == 0) chk("c_unexpected_done", 32'd1, 32'd0);
      else begin
        e = exp_c_q.pop_front();
        cmp_result("c", e, pass_c, err_c, fev_c, fep_c);
      end
    end
    done_c_prev = done_c;
  end

  // ---------------- driver tasks ----------------
  function automatic int nlen(input int id);
    return (id == 0) ? NA : (id == 1) ? NB : NC;
  endfunction

  function automatic int qsize(input int id);
    return (id == 0) ? exp_a_q.size() : (id == 1) ? exp_b_q.size() : exp_c_q.size();
  endfunction

  task automatic issue(input int id, input logic [7:0] mask);
    int k;
    @(negedge clk);
    case (id)
      0: begin mask_a = mask; start_a = 1'b1; end
      1: begin mask_b = mask; start_b = 1'b1; end
      default: begin mask_c = mask; start_c = 1'b1; end
    endcase
    @(posedge clk);
    #1;
    k = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    case (id)
      0: exp_a_q.push_back({32'(k + NA), ref_result(mask, PA)});
      1: exp_b_q.push_back({32'(k + NB), ref_result(mask, PB)});
      default: exp_c_q.push_back({32'(k + NC), ref_result(mask, PC)});
    endcase
  endtask

  task automatic poke(input int id, input int delay);
    repeat (delay) @(negedge clk);
    case (id)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_idle(input int id, input int bound);
    for (int i = 0; i < bound && qsize(id) != 0; i++) @(negedge clk);
    if (qsize(id) != 0) begin
      chk("run_timeout_pending", 32'(qsize(id)), 32'd0);
      case (id)
        0: exp_a_q.delete();
        1: exp_b_q.delete();
        default: exp_c_q.delete();
      endcase
    end
  endtask

  task automatic run(input int id, input logic [7:0] mask, input bit do_poke);
    issue(id, mask);
    if (do_poke) poke(id, $urandom_range(1, nlen(id) - 4));
    wait_idle(id, nlen(id) + 10);
    @(negedge clk);
  endtask

  task automatic check_reset_a(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'd0);
    chk({tag, "_done"}, 32'(done_a), 32'd0);
    chk({tag, "_pass"}, 32'(pass_a), 32'd0);
    chk({tag, "_err_count"}, 32'(err_a), 32'd0);
    chk({tag, "_first_err_valid"}, 32'(fev_a), 32'd0);
    chk({tag, "_first_err_pattern"}, 32'(fep_a), 32'd0);
    chk({tag, "_dut_in"}, 32'({in0_a, in1_a, in2_a}), 32'd0);
    chk({tag, "_state"}, 32'(st_a), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] m;
    n_chk = 0;
    n_pass = 0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    mask_a = '0; mask_b = '0; mask_c = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_a("reset");
    chk("reset_b_busy", 32'(busy_b), 32'd0);
    chk("reset_c_done", 32'(done_c), 32'd0);
    #3 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed: correct detector, stuck-at-0, stuck-at-1, then clean rerun.
    run(0, 8'h00, 1'b0);
    run(0, stuck_mask(1'b0), 1'b0);
    run(0, stuck_mask(1'b1), 1'b0);
    run(0, stuck_mask(1'b0), 1'b1);
    run(0, 8'h00, 1'b0);

    // Randomized fault masks, some runs with a stray start mid-sweep.
    for (int i = 0; i < 16; i++) begin
      m = (i % 4 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      run(0, m, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a sweep, then a clean full run.
    issue(0, stuck_mask(1'b0));
    repeat ($urandom_range(3, NA - 3)) @(negedge clk);
    #3;
    exp_a_q.delete();
    rst_n = 1'b0;
    #1;
    check_reset_a("midrun_reset");
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    run(0, 8'h00, 1'b0);

    // Long run: saturation, then an unsaturated random pair of faults.
    run(1, stuck_mask(1'b0), 1'b1);
    m = 8'h00;
    m[$urandom_range(0, 3)] = 1'b1;
    m[$urandom_range(4, 7)] = 1'b1;
    run(1, m, 1'b0);

    // Longer settle window, multiple passes.
    for (int i = 0; i < 4; i++) begin
      run(2, (i == 0) ? 8'h00 : 8'($urandom_range(0, 255)), bit'(i % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
